l1_evict_sender: RTL
====================

// Module: l1_evict_sender
// PURPOSE
//  Transmit side of the victim-cache write path. Accepts lines evicted by the L1 dcache
//  (44b phys tag, 6b index, 512b data) on a valid/ready handshake and buffers them in a small FIFO.
//  Drains the FIFO into the victim cache as single-cycle write pulses (write_en/addr/tag/data).
//  Because a victim-cache write squashes the lookup issued that cycle, writes yield to lookups,
//  bounded by an anti-starvation deferral counter.
// PARAMETERS
//  DEPTH      4  FIFO entries; power of 2, >=2
//  MAX_DEFER  8  consecutive cycles a pending write may yield to rd_req before it is forced out
// PORTS
//  clk          in   1    clock
//  reset        in   1    reset; asynchronous assert, active-low
//  evict_valid  in   1    L1 offers an evicted line
//  evict_ready  out  1    sender can accept; transfer occurs when evict_valid && evict_ready
//  evict_tag    in   44   physical tag of evicted line
//  evict_index  in   6    set index (vaddr[11:6]) of evicted line
//  evict_data   in   512  evicted line data
//  rd_req       in   1    victim-cache lookup is being issued this cycle
//  vc_write_en  out  1    one-cycle write strobe to victim cache
//  vc_addr      out  12   {index, 6'b0}
//  vc_tag       out  44   tag written alongside data
//  vc_data      out  512  line written
//  count        out  $clog2(DEPTH+1)  occupied entries
//  empty        out  1    count==0
// BEHAVIOUR
//  - Reset (reset==0): FIFO pointers, count=0, empty=1, evict_ready=0 while asserted,
//    vc_write_en=0, vc_addr/vc_tag/vc_data=0, defer_cnt=0, state=IDLE. Entries in flight are dropped.
//  - evict_ready = (count<DEPTH) || (state==PUSH); a full FIFO still accepts in the cycle it pops.
//  - FSM: IDLE (empty) -> ARB when count becomes nonzero.
//    ARB: if !rd_req || defer_cnt==MAX_DEFER -> PUSH (load vc_* regs from head);
//    else defer_cnt++ (saturating), remain in ARB.
//    PUSH: vc_write_en=1 for exactly this cycle, head popped, defer_cnt=0;
//    next state ARB if post-pop count>0, else IDLE.
//  - All vc_* outputs are registered; vc_write_en is never high on consecutive cycles (at most one write per 2 cycles).
//  - Latency: accepted into an empty FIFO with rd_req=0 at cycle N -> vc_write_en at cycle N+2.
//  - Simultaneous push and pop: count unchanged; the new entry goes to the tail, FIFO order is preserved.
//  - Forced write (defer_cnt==MAX_DEFER) is issued even with rd_req=1; the squashed lookup is the caller's problem.
//  - vc_data/vc_tag/vc_addr hold their last value when vc_write_en=0.
// CONFIGURATION
//  EVICT_MERGE_EN defined: an incoming line whose {tag,index} matches a queued entry overwrites that
//    entry's data in place. count is unchanged and evict_ready stays high even when full.
//    The entry being popped this cycle (PUSH head) is excluded from the match and allocates normally.
//  EVICT_MERGE_EN undefined: every accepted line allocates a new entry; duplicates drain in order.
// STRUCTURE
//  vc_pkg: TAG_W=44, IDX_W=6, OFF_W=6, LINE_W=512, typedef struct packed {tag, index, data} evict_entry_t,
//    typedef enum {IDLE, ARB, PUSH} evict_state_t.
//  Sub-module evict_fifo: evict_entry_t storage, rd/wr pointers, count, full/empty.
//    Under EVICT_MERGE_EN it also exposes a parallel match vector and an in-place write port.
//  Top: handshake, FSM, defer counter, vc_* output registers.
// TESTING
//  1 Reset mid-PUSH with 3 entries queued -> vc_write_en=0 and count=0 immediately; no write after release.
//  2 One eviction (tag=0xABC, idx=5), rd_req=0 -> vc_write_en at N+2, vc_addr=0x140, vc_tag=0xABC.
//  3 Fill 4 entries, hold evict_valid -> evict_ready=0 in ARB, =1 in PUSH; simultaneous accept keeps count=4.
//  4 rd_req held 1 with 1 entry -> 8 deferral cycles, then forced vc_write_en with rd_req=1; defer_cnt returns to 0.
//  5 rd_req toggling 1,0 -> writes occur only in cycles following rd_req=0; order matches enqueue order.
//  6 Two evictions with equal {tag,idx}, data A then B -> merge on: one write of B, count=1;
//    merge off: write A then B.

Source files
------------

// File: rtl/vc_pkg.sv
// rtl/vc_pkg.sv - shared widths, FIFO entry layout and sender FSM states for the victim-cache write path
package vc_pkg;

  localparam int TAG_W   = 44;
  localparam int IDX_W   = 6;
  localparam int OFF_W   = 6;
  localparam int LINE_W  = 512;
  localparam int ADDR_W  = IDX_W + OFF_W;
  localparam int KEY_W   = TAG_W + IDX_W;
  localparam int ENTRY_W = KEY_W + LINE_W;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  index;
    logic [LINE_W-1:0] data;
  } evict_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    PUSH
  } evict_state_t;

endpackage

// File: rtl/evict_fifo.sv
// rtl/evict_fifo.sv - eviction entry FIFO; EVICT_MERGE_EN adds a {tag,index} match vector and in-place data write
module evict_fifo
  import vc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wr_entry,
  output logic [ENTRY_W-1:0] head,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
`ifdef EVICT_MERGE_EN
  ,
  output logic [PW-1:0]      rd_ptr,
  input  logic [KEY_W-1:0]   match_key,
  output logic [DEPTH-1:0]   match_vec,
  input  logic               merge_we,
  input  logic [PW-1:0]      merge_idx,
  input  logic [LINE_W-1:0]  merge_data
`endif
);

  evict_entry_t  mem_q [DEPTH];
  evict_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = evict_entry_t'(wr_entry);
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
`ifdef EVICT_MERGE_EN
    if (merge_we) mem_d[merge_idx].data = merge_data;
`endif
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Line storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef EVICT_MERGE_EN
  assign rd_ptr = rd_ptr_q;

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PW-1:0] offs;
    assign offs         = PW'(i) - rd_ptr_q;
    assign match_vec[i] = (CW'(offs) < count_q) &&
                          ({mem_q[i].tag, mem_q[i].index} == match_key);
  end
`endif

endmodule

// File: rtl/l1_evict_sender.sv
// rtl/l1_evict_sender.sv - L1 eviction sender: buffers victims, writes them to the victim cache around lookups (EVICT_MERGE_EN merges duplicates)
module l1_evict_sender
  import vc_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_DEFER = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int DW = $clog2(MAX_DEFER + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              evict_valid,
  output logic              evict_ready,
  input  logic [TAG_W-1:0]  evict_tag,
  input  logic [IDX_W-1:0]  evict_index,
  input  logic [LINE_W-1:0] evict_data,
  input  logic              rd_req,
  output logic              vc_write_en,
  output logic [ADDR_W-1:0] vc_addr,
  output logic [TAG_W-1:0]  vc_tag,
  output logic [LINE_W-1:0] vc_data,
  output logic [CW-1:0]     count,
  output logic              empty
);

  evict_state_t       state_q, state_d;
  logic [DW-1:0]      defer_q, defer_d;
  logic               vc_write_en_q, vc_write_en_d;
  logic [ADDR_W-1:0]  vc_addr_q, vc_addr_d;
  logic [TAG_W-1:0]   vc_tag_q, vc_tag_d;
  logic [LINE_W-1:0]  vc_data_q, vc_data_d;
  logic [ENTRY_W-1:0] head_vec;
  evict_entry_t       head_e;
  logic [LINE_W-1:0]  head_data;
  logic [CW-1:0]      count_next;
  logic               fifo_full, pop, push, fire, merge_hit;

  assign head_e      = evict_entry_t'(head_vec);
  assign pop         = (state_q == PUSH);
  assign evict_ready = reset && (!fifo_full || pop || merge_hit);
  assign fire        = evict_valid && evict_ready;
  assign push        = fire && !merge_hit;
  assign count_next  = count + CW'(push) - CW'(pop);

`ifdef EVICT_MERGE_EN
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0]    rd_ptr, merge_idx;
  logic [DEPTH-1:0] match_vec, merge_vec;

  // The head leaving this cycle must not absorb a merge, or the new data would vanish with it.
  assign merge_vec = match_vec & ~(pop ? (DEPTH'(1) << rd_ptr) : '0);
  assign merge_hit = |merge_vec;

  always_comb begin
    merge_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (merge_vec[i]) merge_idx = PW'(i);
    end
  end

  // A merge into the head on the cycle it is latched for writing forwards the fresh line.
  assign head_data = (fire && merge_hit && (merge_idx == rd_ptr)) ? evict_data : head_e.data;
`else
  assign merge_hit = 1'b0;
  assign head_data = head_e.data;
`endif

  evict_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .wr_entry  ({evict_tag, evict_index, evict_data}),
    .head      (head_vec),
    .count     (count),
    .full      (fifo_full),
    .empty     (empty)
`ifdef EVICT_MERGE_EN
    ,
    .rd_ptr    (rd_ptr),
    .match_key ({evict_tag, evict_index}),
    .match_vec (match_vec),
    .merge_we  (fire && merge_hit),
    .merge_idx (merge_idx),
    .merge_data(evict_data)
`endif
  );

  always_comb begin
    state_d       = state_q;
    defer_d       = defer_q;
    vc_write_en_d = 1'b0;
    vc_addr_d     = vc_addr_q;
    vc_tag_d      = vc_tag_q;
    vc_data_d     = vc_data_q;
    case (state_q)
      IDLE: begin
        if (count_next != '0) state_d = ARB;
      end
      ARB: begin
        if (!rd_req || (defer_q == DW'(MAX_DEFER))) begin
          state_d       = PUSH;
          vc_write_en_d = 1'b1;
          vc_addr_d     = {head_e.index, {OFF_W{1'b0}}};
          vc_tag_d      = head_e.tag;
          vc_data_d     = head_data;
        end else begin
          defer_d = defer_q + 1'b1;
        end
      end
      PUSH: begin
        defer_d = '0;
        state_d = (count_next != '0) ? ARB : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      defer_q       <= '0;
      vc_write_en_q <= 1'b0;
      vc_addr_q     <= '0;
      vc_tag_q      <= '0;
      vc_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      defer_q       <= defer_d;
      vc_write_en_q <= vc_write_en_d;
      vc_addr_q     <= vc_addr_d;
      vc_tag_q      <= vc_tag_d;
      vc_data_q     <= vc_data_d;
    end
  end

  assign vc_write_en = vc_write_en_q;
  assign vc_addr     = vc_addr_q;
  assign vc_tag      = vc_tag_q;
  assign vc_data     = vc_data_q;

endmodule
